// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad scanner with press/release debounce, one-cycle accept strobe and two-digit history.
// Define KEYPAD_SYNC_EN to pass rows through a two-flop synchronizer before any decision.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV = 4096,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] digit0,
   output logic [3:0] digit1
);
   localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int W = $clog2(MAXC + 1);
   localparam logic [W-1:0] SCAN_LAST = W'(SCAN_DIV - 1);
   localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);
   // nibble {row, col} holds the hex code of that key
   localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
   typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;
   state_t state, state_n;
   logic [1:0] col, col_n, row, row_n;
   logic [W-1:0] scnt, scnt_n, dcnt, dcnt_n;
   logic kv_n, hit;
   logic [3:0] code_n, d0_n, d1_n, rs, code;
`ifdef KEYPAD_SYNC_EN
   logic [3:0] sync1, sync2;
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 4'hf;
         sync2 <= 4'hf;
      end else begin
         sync1 <= rows;
         sync2 <= sync1;
      end
   end
   assign rs = sync2;
`else
   assign rs = rows;
`endif
   assign code = KEYMAP[{row, col, 2'b00} +: 4];
   assign hit = ~rs[row];
   assign cols = ~(4'b0001 << col);
   always_comb begin
      state_n = state;
      col_n = col;
      row_n = row;
      scnt_n = '0;
      dcnt_n = dcnt;
      kv_n = 1'b0;
      code_n = key_code;
      d0_n = digit0;
      d1_n = digit1;
      case (state)
         SCAN: begin
            scnt_n = scnt + 1'b1;
            if (scnt == SCAN_LAST) begin
               scnt_n = '0;
               if (rs != 4'hf) begin
                  state_n = PRESS_DB;
                  dcnt_n = '0;
                  row_n = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
               end else
                  col_n = col + 1'b1;
            end
         end
         PRESS_DB: begin
            dcnt_n = dcnt + 1'b1;
            if (!hit) begin
               state_n = SCAN;
               col_n = col + 1'b1;
            end else if (dcnt == DB_LAST) begin
               state_n = HELD;
               kv_n = 1'b1;
               code_n = code;
               d0_n = code;
               d1_n = digit0;
            end
         end
         HELD:
            if (!hit) begin
               state_n = RELEASE_DB;
               dcnt_n = '0;
            end
         RELEASE_DB:
            // any low sample restarts the release qualification
            if (hit)
               dcnt_n = '0;
            else if (dcnt == DB_LAST) begin
               state_n = SCAN;
               col_n = col + 1'b1;
               dcnt_n = '0;
            end else
               dcnt_n = dcnt + 1'b1;
         default: state_n = SCAN;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= SCAN;
         col <= 2'd0;
         row <= 2'd0;
         scnt <= '0;
         dcnt <= '0;
         key_valid <= 1'b0;
         key_code <= 4'h0;
         digit0 <= 4'h0;
         digit1 <= 4'h0;
      end else begin
         state <= state_n;
         col <= col_n;
         row <= row_n;
         scnt <= scnt_n;
         dcnt <= dcnt_n;
         key_valid <= kv_n;
         key_code <= code_n;
         digit0 <= d0_n;
         digit1 <= d1_n;
      end
   end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: drives a modelled 4x4 keypad and checks timing, codes and digit history.
module tb_keypad_scan_ctrl;
   localparam int SD = 4;
   localparam int DB = 8;
   logic clk = 1'b0;
   logic reset;
   logic [3:0] rows, cols, key_code, digit0, digit1;
   logic key_valid;
   logic [15:0] pressed = '0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic [3:0] m_d0, m_d1, m_code;
   logic [3:0] km [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                             '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'hE, 4'h0, 4'hF, 4'hD}};

   keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .rows(rows), .cols(cols), .key_valid(key_valid),
      .key_code(key_code), .digit0(digit0), .digit1(digit1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // physical keypad: a pressed key pulls its row low while its column is driven low
   always_comb begin
      rows = 4'hf;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && cols[c] === 1'b0) rows[r] = 1'b0;
   end

   function automatic logic [3:0] cp(input int c);
      logic [3:0] v;
      v = 4'hf;
      v[c % 4] = 1'b0;
      return v;
   endfunction

   task automatic model_reset();
      m_d0 = 4'h0;
      m_d1 = 4'h0;
      m_code = 4'h0;
   endtask

   task automatic hold_check(input int c, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (key_valid !== 1'b0 || cols !== cp(c)) begin
            errors++;
            $display("FAIL %s hold: kv=%b cols=%b, want kv=0 cols=%b", tag, key_valid, cols, cp(c));
         end
      end
   endtask

   task automatic do_press(input int r, input int c, input int extra);
      int t_col, t_kv;
      t_col = -1;
      t_kv = -1;
      for (int i = 0; i < 50 && cols === cp(c); i++) @(negedge clk);
      pressed[r*4+c] = 1'b1;
      if (extra >= 0) pressed[extra] = 1'b1;
      for (int i = 0; i < 100 && t_kv < 0; i++) begin
         @(negedge clk);
         if (t_col < 0 && cols === cp(c)) t_col = cyc;
         if (key_valid === 1'b1) t_kv = cyc;
      end
      m_d1 = m_d0;
      m_d0 = km[r][c];
      m_code = km[r][c];
      checks++;
      if (t_kv < 0 || t_col < 0 || t_kv - t_col != SD + DB) begin
         errors++;
         $display("FAIL latency key %h: got %0d cycles, want %0d", m_code, t_kv - t_col, SD + DB);
      end
      checks++;
      if (key_code !== m_code) begin
         errors++;
         $display("FAIL key_code: got %h want %h", key_code, m_code);
      end
      checks++;
      if (digit0 !== m_d0 || digit1 !== m_d1) begin
         errors++;
         $display("FAIL digits: got %h%h want %h%h", digit1, digit0, m_d1, m_d0);
      end
   endtask

   // first high sample leaves HELD, then DB consecutive highs return to SCAN
   task automatic release_key(input int r, input int c);
      pressed[r*4+c] = 1'b0;
      for (int i = 1; i <= DB + 1; i++) begin
         @(negedge clk);
         checks++;
         if (key_valid !== 1'b0 || cols !== (i == DB + 1 ? cp(c + 1) : cp(c))) begin
            errors++;
            $display("FAIL release step %0d: kv=%b cols=%b", i, key_valid, cols);
         end
      end
      checks++;
      if (key_code !== m_code || digit0 !== m_d0 || digit1 !== m_d1) begin
         errors++;
         $display("FAIL stable outputs: got %h %h%h want %h %h%h", key_code, digit1, digit0, m_code, m_d1, m_d0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      checks++;
      if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || digit0 !== 4'h0 || digit1 !== 4'h0) begin
         errors++;
         $display("FAIL reset: cols=%b kv=%b code=%h d=%h%h want 1110 0 0 00", cols, key_valid, key_code, digit1, digit0);
      end
      reset = 1'b1;
      for (int i = 1; i <= SD; i++) begin
         @(negedge clk);
         checks++;
         if (cols !== (i == SD ? 4'b1101 : 4'b1110)) begin
            errors++;
            $display("FAIL scan step %0d: cols=%b", i, cols);
         end
      end
   endtask

   task automatic test_clean_press();
      do_press(1, 1, -1);
      hold_check(1, 100, "key5");
      release_key(1, 1);
   endtask

   task automatic test_second_key();
      do_press(3, 2, -1);
      hold_check(2, $urandom_range(1, 20), "keyF");
      release_key(3, 2);
   endtask

   task automatic test_bounce();
      int len;
      len = $urandom_range(1, DB - 1);
      for (int i = 0; i < 50 && cols === cp(0); i++) @(negedge clk);
      pressed[0] = 1'b1;
      for (int i = 0; i < 50 && cols !== cp(0); i++) @(negedge clk);
      hold_check(0, SD + len, "bounce");
      pressed[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (cols !== cp(1) || key_valid !== 1'b0) begin
         errors++;
         $display("FAIL bounce resume: cols=%b kv=%b want %b 0", cols, key_valid, cp(1));
      end
      checks++;
      if (key_code !== m_code || digit0 !== m_d0 || digit1 !== m_d1) begin
         errors++;
         $display("FAIL bounce outputs: got %h %h%h want %h %h%h", key_code, digit1, digit0, m_code, m_d1, m_d0);
      end
   endtask

   task automatic test_simultaneous();
      do_press(0, 0, 4);
      pressed[4] = 1'b0;
      hold_check(0, 20, "r1 release");
      release_key(0, 0);
   endtask

   task automatic test_release_bounce();
      do_press(0, 3, -1);
      repeat (4) begin
         pressed[3] = 1'b0;
         hold_check(3, 3, "rb high");
         pressed[3] = 1'b1;
         hold_check(3, 3, "rb low");
      end
      pressed[3] = 1'b0;
      for (int i = 1; i <= DB; i++) begin
         @(negedge clk);
         checks++;
         if (key_valid !== 1'b0 || cols !== (i == DB ? cp(0) : cp(3))) begin
            errors++;
            $display("FAIL settle step %0d: kv=%b cols=%b", i, key_valid, cols);
         end
      end
   endtask

   task automatic test_reset_abort();
      for (int i = 0; i < 50 && cols === cp(2); i++) @(negedge clk);
      pressed[10] = 1'b1;
      for (int i = 0; i < 50 && cols !== cp(2); i++) @(negedge clk);
      hold_check(2, SD + 3, "pre-reset");
      reset = 1'b0;
      pressed[10] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      checks++;
      if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || digit0 !== 4'h0 || digit1 !== 4'h0) begin
         errors++;
         $display("FAIL mid reset: cols=%b kv=%b code=%h d=%h%h", cols, key_valid, key_code, digit1, digit0);
      end
      for (int i = 0; i < 5 * SD; i++) begin
         @(negedge clk);
         checks++;
         if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL aborted key pulsed: kv=%b want 0", key_valid);
         end
      end
      do_press(2, 2, -1);
      hold_check(2, 4, "key9");
      reset = 1'b0;
      pressed[10] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 3 * SD; i++) begin
         @(negedge clk);
         checks++;
         if (key_valid !== 1'b0 || digit0 !== 4'h0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL held reset: kv=%b d0=%h code=%h want 0 0 0", key_valid, digit0, key_code);
         end
      end
   endtask

   task automatic test_back_to_back();
      int r, c;
      repeat (6) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         do_press(r, c, -1);
         hold_check(c, $urandom_range(1, 20), "random");
         release_key(r, c);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_second_key();
      test_bounce();
      test_simultaneous();
      test_release_bounce();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
